// File: rtl/avalon_mm_cpuif_bridge.sv
// Pipelined Avalon-MM agent onto the regblock CPU-interface request/ack bus.
// Up to MAX_OUTSTANDING commands are in flight; their kinds are queued so acks retire in accept order.
module avalon_mm_cpuif_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BYTE_LSB       = $clog2(DATA_WIDTH / 8)
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           read,
    input  logic                           write,
    output logic                           waitrequest,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          writedata,
    input  logic [DATA_WIDTH/8-1:0]        byteenable,
    output logic                           readdatavalid,
    output logic                           writeresponsevalid,
    output logic [DATA_WIDTH-1:0]          readdata,
    output logic [1:0]                     response,
    output logic                           cpuif_req,
    output logic                           cpuif_req_is_wr,
    output logic [ADDR_WIDTH+BYTE_LSB-1:0] cpuif_addr,
    output logic [DATA_WIDTH-1:0]          cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]          cpuif_wr_biten,
    input  logic                           cpuif_req_stall_wr,
    input  logic                           cpuif_req_stall_rd,
    input  logic                           cpuif_rd_ack,
    input  logic                           cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]          cpuif_rd_data,
    input  logic                           cpuif_wr_ack,
    input  logic                           cpuif_wr_err,
    output logic                           unexpected_ack
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CAW   = ADDR_WIDTH + BYTE_LSB;

    logic                       is_wr, is_rd, accept;
    logic                       have_head, head_is_wr, pop_wr, pop_rd, pop;
    logic [MAX_OUTSTANDING-1:0] order_q;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;

    // Handshake: a command transfers in any cycle where (read|write) is high and
    // waitrequest is low; waitrequest never depends on the ack inputs.
    assign is_wr       = write;
    assign is_rd       = read & ~write;
    assign waitrequest = ~arst_n | (count == CNT_W'(MAX_OUTSTANDING))
                       | (is_wr & cpuif_req_stall_wr) | (is_rd & cpuif_req_stall_rd);
    assign accept      = (read | write) & ~waitrequest;

    assign cpuif_req       = accept;
    assign cpuif_req_is_wr = is_wr;
    assign cpuif_addr      = CAW'(address) << BYTE_LSB;
    assign cpuif_wr_data   = writedata;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_biten
        assign cpuif_wr_biten[i] = byteenable[i/8];
    end

    // With an empty queue the command being accepted this cycle is the head,
    // which lets a same-cycle ack retire it.
    assign have_head  = (count != '0) | accept;
    assign head_is_wr = (count == '0) ? is_wr : order_q[rd_ptr];
    assign pop_wr     = have_head & head_is_wr & cpuif_wr_ack;
    assign pop_rd     = have_head & ~head_is_wr & cpuif_rd_ack;
    assign pop        = pop_wr | pop_rd;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            order_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                order_q[wr_ptr] <= is_wr;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (accept && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            readdatavalid      <= 1'b0;
            writeresponsevalid <= 1'b0;
            readdata           <= '0;
            response           <= 2'b00;
            unexpected_ack     <= 1'b0;
        end else begin
            readdatavalid      <= pop_rd;
            writeresponsevalid <= pop_wr;
            readdata           <= pop_rd ? cpuif_rd_data : '0;
            if (pop_rd) begin
                response <= {cpuif_rd_err, 1'b0};
            end else if (pop_wr) begin
                response <= {cpuif_wr_err, 1'b0};
            end else begin
                response <= 2'b00;
            end
            if ((cpuif_wr_ack && !pop_wr) || (cpuif_rd_ack && !pop_rd)) begin
                unexpected_ack <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_avalon_mm_cpuif_bridge.sv
// Directed bench for avalon_mm_cpuif_bridge: inputs change just after a rising edge,
// combinational outputs are checked 1ns later, registered outputs after the next edge.
module tb_avalon_mm_cpuif_bridge;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        read, write, waitrequest;
    logic [31:0] address, writedata;
    logic [3:0]  byteenable;
    logic        readdatavalid, writeresponsevalid;
    logic [31:0] readdata;
    logic [1:0]  response;
    logic        cpuif_req, cpuif_req_is_wr;
    logic [33:0] cpuif_addr;
    logic [31:0] cpuif_wr_data, cpuif_wr_biten;
    logic        cpuif_req_stall_wr, cpuif_req_stall_rd;
    logic        cpuif_rd_ack, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err;
    logic [31:0] cpuif_rd_data;
    logic        unexpected_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avalon_mm_cpuif_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .arst_n(arst_n), .read(read), .write(write), .waitrequest(waitrequest),
        .address(address), .writedata(writedata), .byteenable(byteenable),
        .readdatavalid(readdatavalid), .writeresponsevalid(writeresponsevalid),
        .readdata(readdata), .response(response), .cpuif_req(cpuif_req),
        .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
        .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
        .cpuif_req_stall_wr(cpuif_req_stall_wr), .cpuif_req_stall_rd(cpuif_req_stall_rd),
        .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
        .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err), .unexpected_ack(unexpected_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read = 0; write = 0; address = '0; writedata = '0; byteenable = '0;
        cpuif_req_stall_wr = 0; cpuif_req_stall_rd = 0;
        cpuif_rd_ack = 0; cpuif_rd_err = 0; cpuif_rd_data = '0;
        cpuif_wr_ack = 0; cpuif_wr_err = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_n = 0;
        read = 1;
        tick();
        total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL rst_waitrequest got=%0h exp=1", waitrequest); end
        total++; if (cpuif_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", cpuif_req); end
        total++; if ({readdatavalid, writeresponsevalid} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%0b exp=00", {readdatavalid, writeresponsevalid}); end
        total++; if (readdata !== 32'h0 || response !== 2'b00) begin bad++; $display("FAIL rst_data got=%0h/%0b exp=0/00", readdata, response); end
        total++; if (unexpected_ack !== 1'b0) begin bad++; $display("FAIL rst_unexp got=%0h exp=0", unexpected_ack); end
        read = 0;
        tick();
        arst_n = 1;
        tick();
    endtask

    task automatic test_single_read();
        read = 1; address = 32'h10; cpuif_rd_ack = 1; cpuif_rd_data = 32'hDEADBEEF;
        #1;
        total++; if (waitrequest !== 1'b0) begin bad++; $display("FAIL rd_waitrequest got=%0h exp=0", waitrequest); end
        total++; if (cpuif_req !== 1'b1 || cpuif_req_is_wr !== 1'b0) begin bad++; $display("FAIL rd_req got=%0b%0b exp=10", cpuif_req, cpuif_req_is_wr); end
        total++; if (cpuif_addr !== 34'h40) begin bad++; $display("FAIL rd_addr got=%0h exp=40", cpuif_addr); end
        tick();
        idle_inputs();
        total++; if (readdatavalid !== 1'b1 || writeresponsevalid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%0b%0b exp=10", readdatavalid, writeresponsevalid); end
        total++; if (readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%0h exp=deadbeef", readdata); end
        total++; if (response !== 2'b00) begin bad++; $display("FAIL rd_resp got=%0b exp=00", response); end
        tick();
        total++; if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin bad++; $display("FAIL rd_idle got=%0h/%0h exp=0/0", readdatavalid, readdata); end
    endtask

    task automatic test_partial_write_err();
        write = 1; address = 32'h3; writedata = 32'h11223344; byteenable = 4'b0101;
        cpuif_wr_ack = 1; cpuif_wr_err = 1;
        #1;
        total++; if (cpuif_wr_biten !== 32'h00FF00FF) begin bad++; $display("FAIL wr_biten got=%0h exp=00ff00ff", cpuif_wr_biten); end
        total++; if (cpuif_req !== 1'b1 || cpuif_req_is_wr !== 1'b1) begin bad++; $display("FAIL wr_req got=%0b%0b exp=11", cpuif_req, cpuif_req_is_wr); end
        total++; if (cpuif_addr !== 34'hC || cpuif_wr_data !== 32'h11223344) begin bad++; $display("FAIL wr_addr_data got=%0h/%0h exp=c/11223344", cpuif_addr, cpuif_wr_data); end
        tick();
        idle_inputs();
        total++; if (writeresponsevalid !== 1'b1 || readdatavalid !== 1'b0) begin bad++; $display("FAIL wr_valid got=%0b%0b exp=10", writeresponsevalid, readdatavalid); end
        total++; if (response !== 2'b10) begin bad++; $display("FAIL wr_resp got=%0b exp=10", response); end
        tick();
        total++; if (writeresponsevalid !== 1'b0 || response !== 2'b00) begin bad++; $display("FAIL wr_idle got=%0h/%0b exp=0/00", writeresponsevalid, response); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            read = 1; address = 32'(i);
            #1;
            total++; if (waitrequest !== 1'b0) begin bad++; $display("FAIL bp_accept%0d got=%0h exp=0", i, waitrequest); end
            tick();
        end
        read = 1; address = 32'h4;
        #1;
        total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL bp_full got=%0h exp=1", waitrequest); end
        cpuif_rd_ack = 1; cpuif_rd_data = 32'hA0;
        #1;
        total++; if (waitrequest !== 1'b1 || cpuif_req !== 1'b0) begin bad++; $display("FAIL bp_ack_same_cycle got=%0b%0b exp=10", waitrequest, cpuif_req); end
        tick();
        cpuif_rd_ack = 0;
        total++; if (readdatavalid !== 1'b1 || readdata !== 32'hA0) begin bad++; $display("FAIL bp_first_resp got=%0h/%0h exp=1/a0", readdatavalid, readdata); end
        #1;
        total++; if (waitrequest !== 1'b0 || cpuif_req !== 1'b1) begin bad++; $display("FAIL bp_fifth_accept got=%0b%0b exp=01", waitrequest, cpuif_req); end
        tick();
        read = 0;
        for (int i = 0; i < 4; i++) begin
            cpuif_rd_ack = 1; cpuif_rd_data = 32'hB0 + 32'(i);
            tick();
            total++; if (readdatavalid !== 1'b1 || readdata !== 32'hB0 + 32'(i)) begin bad++; $display("FAIL bp_drain%0d got=%0h/%0h exp=1/%0h", i, readdatavalid, readdata, 32'hB0 + i); end
        end
        idle_inputs();
        tick();
        total++; if (readdatavalid !== 1'b0 || unexpected_ack !== 1'b0) begin bad++; $display("FAIL bp_end got=%0b%0b exp=00", readdatavalid, unexpected_ack); end
    endtask

    task automatic test_mixed_order();
        read = 1; address = 32'h1; tick();
        read = 0; write = 1; address = 32'h2; byteenable = 4'hF; tick();
        write = 0; read = 1; address = 32'h3; tick();
        idle_inputs(); tick();
        cpuif_rd_ack = 1; cpuif_rd_data = 32'h111;
        tick();
        cpuif_rd_ack = 0;
        total++; if ({readdatavalid, writeresponsevalid} !== 2'b10 || readdata !== 32'h111) begin bad++; $display("FAIL mix_r1 got=%0b/%0h exp=10/111", {readdatavalid, writeresponsevalid}, readdata); end
        tick();
        total++; if ({readdatavalid, writeresponsevalid} !== 2'b00) begin bad++; $display("FAIL mix_gap got=%0b exp=00", {readdatavalid, writeresponsevalid}); end
        tick();
        cpuif_wr_ack = 1;
        tick();
        cpuif_wr_ack = 0;
        total++; if ({readdatavalid, writeresponsevalid} !== 2'b01 || response !== 2'b00) begin bad++; $display("FAIL mix_w got=%0b/%0b exp=01/00", {readdatavalid, writeresponsevalid}, response); end
        cpuif_rd_ack = 1; cpuif_rd_err = 1; cpuif_rd_data = 32'h333;
        tick();
        idle_inputs();
        total++; if ({readdatavalid, writeresponsevalid} !== 2'b10 || readdata !== 32'h333 || response !== 2'b10) begin bad++; $display("FAIL mix_r2 got=%0b/%0h/%0b exp=10/333/10", {readdatavalid, writeresponsevalid}, readdata, response); end
        tick();
        total++; if (readdatavalid !== 1'b0 || unexpected_ack !== 1'b0) begin bad++; $display("FAIL mix_end got=%0b%0b exp=00", readdatavalid, unexpected_ack); end
    endtask

    task automatic test_stall_dual();
        cpuif_req_stall_rd = 1; read = 1;
        #1;
        total++; if (waitrequest !== 1'b1 || cpuif_req !== 1'b0) begin bad++; $display("FAIL stall_rd got=%0b%0b exp=10", waitrequest, cpuif_req); end
        write = 1; cpuif_wr_ack = 1;
        #1;
        total++; if (waitrequest !== 1'b0 || cpuif_req !== 1'b1 || cpuif_req_is_wr !== 1'b1) begin bad++; $display("FAIL dual_strobe got=%0b%0b%0b exp=011", waitrequest, cpuif_req, cpuif_req_is_wr); end
        tick();
        cpuif_wr_ack = 0; cpuif_req_stall_wr = 1;
        total++; if ({readdatavalid, writeresponsevalid} !== 2'b01) begin bad++; $display("FAIL dual_resp got=%0b exp=01", {readdatavalid, writeresponsevalid}); end
        #1;
        total++; if (waitrequest !== 1'b1 || cpuif_req !== 1'b0) begin bad++; $display("FAIL stall_wr got=%0b%0b exp=10", waitrequest, cpuif_req); end
        idle_inputs();
        tick();
    endtask

    task automatic test_unexpected();
        cpuif_wr_ack = 1;
        tick();
        cpuif_wr_ack = 0;
        total++; if (unexpected_ack !== 1'b1 || writeresponsevalid !== 1'b0) begin bad++; $display("FAIL unexp_set got=%0b%0b exp=10", unexpected_ack, writeresponsevalid); end
        tick();
        total++; if (unexpected_ack !== 1'b1) begin bad++; $display("FAIL unexp_held got=%0h exp=1", unexpected_ack); end
        read = 1; address = 32'h7;
        tick();
        idle_inputs();
        arst_n = 0;
        #1;
        total++; if (unexpected_ack !== 1'b0 || waitrequest !== 1'b1 || readdatavalid !== 1'b0 || response !== 2'b00) begin bad++; $display("FAIL mid_reset got=%0b%0b%0b/%0b exp=010/00", unexpected_ack, waitrequest, readdatavalid, response); end
        tick();
        arst_n = 1;
        tick();
        cpuif_rd_ack = 1; cpuif_rd_data = 32'h55;
        tick();
        cpuif_rd_ack = 0;
        total++; if (unexpected_ack !== 1'b1 || readdatavalid !== 1'b0 || readdata !== 32'h0) begin bad++; $display("FAIL late_ack got=%0b%0b/%0h exp=10/0", unexpected_ack, readdatavalid, readdata); end
        for (int i = 0; i < 4; i++) begin
            read = 1; address = 32'h20 + 32'(i);
            #1;
            total++; if (waitrequest !== 1'b0) begin bad++; $display("FAIL post_rst_accept%0d got=%0h exp=0", i, waitrequest); end
            tick();
        end
        #1;
        total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL post_rst_full got=%0h exp=1", waitrequest); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_partial_write_err();
        test_backpressure();
        test_mixed_order();
        test_stall_dual();
        test_unexpected();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
